// File: rtl/fetch_pc.sv
// Fetch-stage program counter: next-PC selection between exception entry, eret,
// branch/jump redirects and sequential flow, with a one-entry buffer for redirects seen during a stall.
module fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_BYTES = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] pc4,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        j_taken,
  input  logic [31:0] j_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic        redirect_pending,
  output logic        adel_if
);

  logic        pend_valid;
  logic [31:0] pend_target;

  logic [31:0] pc_next;
  logic        pend_valid_next;
  logic [31:0] pend_target_next;

  // Upper bound computed at 33 bits so a window ending at 2^32 does not wrap.
  logic [32:0] im_limit;
  assign im_limit = {1'b0, IM_BASE} + {1'b0, IM_BYTES};

  always_comb begin
    pc_next          = pc;
    pend_valid_next  = pend_valid;
    pend_target_next = pend_target;

    if (exc_req) begin
      pc_next         = EXC_VEC;
      pend_valid_next = 1'b0;
    end else if (eret_req) begin
      pc_next         = epc;
      pend_valid_next = 1'b0;
    end else if (stall) begin
      // PC holds; the newest redirect replaces anything already buffered.
      if (br_taken) begin
        pend_valid_next  = 1'b1;
        pend_target_next = br_target;
      end else if (j_taken) begin
        pend_valid_next  = 1'b1;
        pend_target_next = j_target;
      end
    end else begin
      pend_valid_next = 1'b0;
      if (br_taken) begin
        pc_next = br_target;
      end else if (j_taken) begin
        pc_next = j_target;
      end else if (pend_valid) begin
        pc_next = pend_target;
      end else begin
        pc_next = pc4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      pc          <= pc_next;
      pend_valid  <= pend_valid_next;
      pend_target <= pend_target_next;
    end
  end

  assign redirect_pending = pend_valid;

  always_comb begin
    adel_if = 1'b0;
    if (pc[1:0] != 2'b00)          adel_if = 1'b1;
    if (pc < IM_BASE)              adel_if = 1'b1;
    if ({1'b0, pc} >= im_limit)    adel_if = 1'b1;
  end

endmodule

// File: tb/tb_fetch_pc.sv
// Directed bench for fetch_pc: each step queues the expected post-edge state,
// then compares pc / redirect_pending / adel_if one time unit after the edge.
module tb_fetch_pc;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] pc4;
  logic        br_taken;
  logic [31:0] br_target;
  logic        j_taken;
  logic [31:0] j_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc;
  logic        redirect_pending;
  logic        adel_if;

  int unsigned pass_cnt = 0;
  int unsigned total    = 0;

  typedef struct {
    logic [31:0] pc;
    logic        pend;
    logic        adel;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // External PC+4 adder, 32-bit so it wraps naturally.
  assign pc4 = pc + 32'd4;

  fetch_pc #(
    .RESET_PC (32'h0000_3000),
    .EXC_VEC  (32'h0000_4180),
    .IM_BASE  (32'h0000_3000),
    .IM_BYTES (32'h0000_1000)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .pc4              (pc4),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .j_taken          (j_taken),
    .j_target         (j_target),
    .exc_req          (exc_req),
    .eret_req         (eret_req),
    .epc              (epc),
    .pc               (pc),
    .redirect_pending (redirect_pending),
    .adel_if          (adel_if)
  );

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a >= 32'h0000_4000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) pass_cnt++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, got, want);
  endtask

  task automatic step(input string tag,
                      input logic rst, input logic stl,
                      input logic br, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt,
                      input logic exc, input logic eret, input logic [31:0] ep,
                      input logic [31:0] exp_pc, input logic exp_pend);
    exp_t e;
    reset     = rst;
    stall     = stl;
    br_taken  = br;
    br_target = bt;
    j_taken   = j;
    j_target  = jt;
    exc_req   = exc;
    eret_req  = eret;
    epc       = ep;
    e.pc   = exp_pc;
    e.pend = exp_pend;
    e.adel = addr_err(exp_pc);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL %s scoreboard empty observed=%08h expected=entry", tag, pc);
    end else begin
      e = sb.pop_front();
      chk({tag, ".pc"},   pc,                       e.pc);
      chk({tag, ".pend"}, {31'd0, redirect_pending}, {31'd0, e.pend});
      chk({tag, ".adel"}, {31'd0, adel_if},          {31'd0, e.adel});
    end
  endtask

  // Plain sequential cycle: no redirects, no stall.
  task automatic run(input string tag, input logic [31:0] exp_pc, input logic exp_pend);
    step(tag, 0, 0, 0, '0, 0, '0, 0, 0, '0, exp_pc, exp_pend);
  endtask

  task automatic branch(input string tag, input logic [31:0] tgt);
    step(tag, 0, 0, 1, tgt, 0, '0, 0, 0, '0, tgt, 0);
  endtask

  initial begin
    // reset and free run
    step("rst0", 1, 0, 0, '0, 0, '0, 0, 0, '0, 32'h3000, 0);
    step("rst1", 1, 0, 0, '0, 0, '0, 0, 0, '0, 32'h3000, 0);
    run("seq1", 32'h3004, 0);
    run("seq2", 32'h3008, 0);
    run("seq3", 32'h300C, 0);

    // branch redirect, then sequential from target
    branch("br", 32'h3040);
    run("br_seq", 32'h3044, 0);
    // branch and jump together: branch wins
    step("br_j", 0, 0, 1, 32'h3010, 1, 32'h3500, 0, 0, '0, 32'h3010, 0);

    // jump during stall is buffered and released when stall drops
    step("st_j",  0, 1, 0, '0, 1, 32'h3100, 0, 0, '0, 32'h3010, 1);
    step("st_h1", 0, 1, 0, '0, 0, '0,       0, 0, '0, 32'h3010, 1);
    step("st_h2", 0, 1, 0, '0, 0, '0,       0, 0, '0, 32'h3010, 1);
    run("st_rel", 32'h3100, 0);
    run("st_seq", 32'h3104, 0);

    // newer stalled redirect overwrites older
    step("ow_br", 0, 1, 1, 32'h3200, 0, '0,       0, 0, '0, 32'h3104, 1);
    step("ow_j",  0, 1, 0, '0,       1, 32'h3300, 0, 0, '0, 32'h3104, 1);
    run("ow_rel", 32'h3300, 0);

    // exception beats stall, branch and a pending redirect; eret returns
    branch("to3020", 32'h3020);
    step("pend",  0, 1, 0, '0,       1, 32'h3100, 0, 0, '0,       32'h3020, 1);
    step("exc",   0, 1, 1, 32'h3080, 0, '0,       1, 0, '0,       32'h4180, 0);
    step("eret",  0, 0, 0, '0,       0, '0,       0, 1, 32'h3024, 32'h3024, 0);
    step("eret_st", 0, 1, 1, 32'h3400, 0, '0,     0, 1, 32'h3030, 32'h3030, 0);
    step("exc_eret", 0, 0, 0, '0,    0, '0,       1, 1, 32'h3050, 32'h4180, 0);

    // address-error boundaries
    branch("mis", 32'h3002);
    branch("lo",  32'h2FFC);
    branch("base", 32'h3000);
    branch("top", 32'h3FFC);
    run("end",  32'h4000, 0);
    branch("wrap", 32'hFFFF_FFFC);
    run("wrap0", 32'h0000_0000, 0);

    // reset overrides everything, including a pending redirect
    branch("to3010", 32'h3010);
    step("pend2", 0, 1, 0, '0, 1, 32'h3200, 0, 0, '0, 32'h3010, 1);
    step("rst_mid", 1, 0, 1, 32'h3600, 1, 32'h3300, 1, 1, 32'h3700, 32'h3000, 0);
    run("post_rst", 32'h3004, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
